psum_accumulator: RTL and testbench



---
 rtl/psum_accumulator.sv | 96 +++++++++
 tb/tb_psum_accumulator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Streaming signed accumulator: sums acc_len consecutive partial sums into one wide
// result, with a one-entry output register so the next group can accumulate meanwhile.
module psum_accumulator #(
    parameter int unsigned DATA_IN_BITWIDTH = 16,
    parameter int unsigned ACC_BITWIDTH     = 32,
    parameter int unsigned CNT_BITWIDTH     = 8,
    parameter int unsigned SATURATE         = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [CNT_BITWIDTH-1:0]     acc_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_IN_BITWIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_BITWIDTH-1:0]     out_data,
    output logic                        out_overflow
);

    localparam int unsigned ACC_MSB = ACC_BITWIDTH - 1;
    localparam logic [ACC_BITWIDTH-1:0] ACC_MAX = {1'b0, {ACC_MSB{1'b1}}};
    localparam logic [ACC_BITWIDTH-1:0] ACC_MIN = {1'b1, {ACC_MSB{1'b0}}};

    logic [ACC_BITWIDTH-1:0] acc_q;
    logic [CNT_BITWIDTH-1:0] cnt_q;
    logic [CNT_BITWIDTH-1:0] len_q;
    logic                    ovf_q;

    logic                    first;
    logic [CNT_BITWIDTH-1:0] len_in;
    logic [CNT_BITWIDTH-1:0] len_eff;
    logic                    is_last;
    logic [ACC_BITWIDTH-1:0] op_a;
    logic [ACC_BITWIDTH-1:0] in_ext;
    logic [ACC_BITWIDTH:0]   sum_wide;
    logic                    term_ovf;
    logic [ACC_BITWIDTH-1:0] sum_res;
    logic                    grp_ovf;
    logic                    accept;
    logic                    consume;

    // Group bookkeeping and the one-term adder with overflow detection.
    always_comb begin
        first    = (cnt_q == '0);
        len_in   = (acc_len == '0) ? CNT_BITWIDTH'(1) : acc_len;
        len_eff  = first ? len_in : len_q;
        is_last  = (cnt_q == len_eff - CNT_BITWIDTH'(1));
        op_a     = first ? '0 : acc_q;
        in_ext   = ACC_BITWIDTH'($signed(in_data));
        sum_wide = {op_a[ACC_MSB], op_a} + {in_ext[ACC_MSB], in_ext};
        term_ovf = (op_a[ACC_MSB] == in_ext[ACC_MSB]) &&
                   (sum_wide[ACC_MSB] != op_a[ACC_MSB]);
        sum_res  = sum_wide[ACC_MSB:0];
        if ((SATURATE != 0) && term_ovf) begin
            sum_res = op_a[ACC_MSB] ? ACC_MIN : ACC_MAX;
        end
        grp_ovf  = first ? 1'b0 : ovf_q;
    end

    // Only the last term of a group stalls, and only behind an undrained result.
    assign in_ready = ~is_last | ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            len_q        <= CNT_BITWIDTH'(1);
            ovf_q        <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_overflow <= 1'b0;
        end else if (accept && is_last) begin
            // Reload wins over a simultaneous consume, so no bubble between groups.
            out_data     <= sum_res;
            out_overflow <= grp_ovf | term_ovf;
            out_valid    <= 1'b1;
            cnt_q        <= '0;
        end else begin
            if (accept) begin
                acc_q <= sum_res;
                cnt_q <= cnt_q + CNT_BITWIDTH'(1);
                ovf_q <= grp_ovf | term_ovf;
                if (first) begin
                    len_q <= len_eff;
                end
            end
            if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench: three accumulator configurations share one stimulus stream and
// are compared every cycle against a group-level arithmetic reference model.
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  acc_len = 8'd1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        out_ready = 1'b0;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [31:0] out_data0;
    logic [15:0] out_data1, out_data2;
    logic        out_ovf0, out_ovf1, out_ovf2;

    always #5 clk = ~clk;

    psum_accumulator #(.DATA_IN_BITWIDTH(16), .ACC_BITWIDTH(32), .CNT_BITWIDTH(8), .SATURATE(0)) u_wrap32 (
        .clk(clk), .reset_n(reset_n), .acc_len(acc_len), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_overflow(out_ovf0));

    psum_accumulator #(.DATA_IN_BITWIDTH(16), .ACC_BITWIDTH(16), .CNT_BITWIDTH(8), .SATURATE(1)) u_sat16 (
        .clk(clk), .reset_n(reset_n), .acc_len(acc_len), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_overflow(out_ovf1));

    psum_accumulator #(.DATA_IN_BITWIDTH(16), .ACC_BITWIDTH(16), .CNT_BITWIDTH(8), .SATURATE(0)) u_wrap16 (
        .clk(clk), .reset_n(reset_n), .acc_len(acc_len), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_overflow(out_ovf2));

    int passed = 0;
    int total  = 0;

    // Reference model: group progress plus an exact running sum per configuration.
    int     cfg_w   [3] = '{32, 16, 16};
    bit     cfg_sat [3] = '{1'b0, 1'b1, 1'b0};
    longint m_acc   [3];
    bit     m_ovf   [3];
    longint p_data  [3];
    bit     p_ovf   [3];
    bit     p_valid;
    int     m_cnt;
    int     m_glen;
    bit     exp_ready;
    bit     last_accept;
    int     dut_consumes = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic void step(input int w, input bit sat, input longint a, input longint x,
                                 output longint r, output bit o);
        longint mx = (longint'(1) <<< (w - 1)) - 1;
        longint mn = -(longint'(1) <<< (w - 1));
        longint s  = a + x;
        o = (s > mx) || (s < mn);
        if (s > mx)      r = sat ? mx : s - (longint'(1) <<< w);
        else if (s < mn) r = sat ? mn : s + (longint'(1) <<< w);
        else             r = s;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_glen = 1;
        p_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            p_data[k] = 0;
            p_ovf[k] = 1'b0;
            m_acc[k] = 0;
            m_ovf[k] = 1'b0;
        end
    endtask

    task automatic check_all();
        int eff;
        eff = (m_cnt == 0) ? ((acc_len == 8'd0) ? 1 : int'(acc_len)) : m_glen;
        exp_ready = (m_cnt + 1 != eff) || !p_valid || out_ready;
        chk("in_ready_w32", {63'd0, in_ready0}, {63'd0, exp_ready});
        chk("in_ready_s16", {63'd0, in_ready1}, {63'd0, exp_ready});
        chk("in_ready_w16", {63'd0, in_ready2}, {63'd0, exp_ready});
        chk("out_valid_w32", {63'd0, out_valid0}, {63'd0, p_valid});
        chk("out_valid_s16", {63'd0, out_valid1}, {63'd0, p_valid});
        chk("out_valid_w16", {63'd0, out_valid2}, {63'd0, p_valid});
        chk("out_data_w32", $signed(out_data0), p_data[0]);
        chk("out_data_s16", $signed(out_data1), p_data[1]);
        chk("out_data_w16", $signed(out_data2), p_data[2]);
        chk("out_ovf_w32", {63'd0, out_ovf0}, {63'd0, p_ovf[0]});
        chk("out_ovf_s16", {63'd0, out_ovf1}, {63'd0, p_ovf[1]});
        chk("out_ovf_w16", {63'd0, out_ovf2}, {63'd0, p_ovf[2]});
    endtask

    task automatic model_update();
        bit     consume;
        longint x;
        longint r;
        bit     o;
        last_accept = in_valid && exp_ready;
        consume = p_valid && out_ready;
        if (out_valid0 && out_ready) dut_consumes++;
        if (last_accept) begin
            if (m_cnt == 0) begin
                m_glen = (acc_len == 8'd0) ? 1 : int'(acc_len);
                for (int k = 0; k < 3; k++) begin
                    m_acc[k] = 0;
                    m_ovf[k] = 1'b0;
                end
            end
            x = longint'($signed(in_data));
            for (int k = 0; k < 3; k++) begin
                step(cfg_w[k], cfg_sat[k], m_acc[k], x, r, o);
                m_acc[k] = r;
                m_ovf[k] = m_ovf[k] | o;
            end
            m_cnt++;
            if (m_cnt == m_glen) begin
                p_data = m_acc;
                p_ovf = m_ovf;
                p_valid = 1'b1;
                m_cnt = 0;
            end else if (consume) begin
                p_valid = 1'b0;
            end
        end else if (consume) begin
            p_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x);
        in_valid = 1'b1;
        in_data = 16'(x);
        last_accept = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (last_accept) break;
        end
        if (!last_accept) begin
            total++;
            $error("FAIL send_timeout observed=stalled expected=accepted data=%0d", x);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        int base;
        model_reset();
        #1;
        chk("reset_out_valid", {63'd0, out_valid0}, 0);
        chk("reset_out_data", $signed(out_data0), 0);
        chk("reset_in_ready", {63'd0, in_ready0}, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Wrap sum 1+2+3-10.
        acc_len = 8'd4;
        out_ready = 1'b1;
        send(1); send(2); send(3); send(-10);
        chk("wrap_sum_data", $signed(out_data0), -4);
        chk("wrap_sum_valid", {63'd0, out_valid0}, 1);
        chk("wrap_sum_ovf", {63'd0, out_ovf0}, 0);
        drain();

        // Back-to-back groups with the output held.
        base = dut_consumes;
        acc_len = 8'd2;
        out_ready = 1'b0;
        send(5); send(6); send(7);
        in_valid = 1'b1;
        in_data = 16'd8;
        tick();
        chk("stall_in_ready", {63'd0, in_ready0}, 0);
        chk("stall_first_result", $signed(out_data0), 11);
        out_ready = 1'b1;
        send(8);
        chk("b2b_second_result", $signed(out_data0), 15);
        chk("b2b_second_valid", {63'd0, out_valid0}, 1);
        drain();
        chk("b2b_result_count", dut_consumes - base, 2);

        // Overflow: saturating vs wrapping 16-bit accumulators.
        acc_len = 8'd3;
        send(30000); send(30000); send(-100);
        chk("sat_data", $signed(out_data1), 32667);
        chk("sat_ovf", {63'd0, out_ovf1}, 1);
        chk("wrap16_data", $signed(out_data2), -5636);
        chk("wrap16_ovf", {63'd0, out_ovf2}, 1);
        chk("wide_data", $signed(out_data0), 59900);
        chk("wide_ovf", {63'd0, out_ovf0}, 0);
        drain();

        // acc_len of 0 and 1.
        acc_len = 8'd0;
        send(-7);
        chk("len0_data", $signed(out_data0), -7);
        chk("len0_ovf", {63'd0, out_ovf1}, 0);
        acc_len = 8'd1;
        send(9);
        chk("len1_data", $signed(out_data0), 9);

        // acc_len change mid-group is ignored.
        acc_len = 8'd3;
        send(1);
        acc_len = 8'd1;
        send(2);
        chk("midlen_no_result", {63'd0, out_valid0}, 0);
        send(4);
        chk("midlen_result", $signed(out_data0), 7);
        drain();

        // Reset with a pending result and a half-finished group.
        out_ready = 1'b0;
        acc_len = 8'd1;
        send(3);
        acc_len = 8'd4;
        send(1); send(1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", {63'd0, out_valid0}, 0);
        chk("rst_mid_data", $signed(out_data0), 0);
        chk("rst_mid_ovf", {63'd0, out_ovf1}, 0);
        chk("rst_mid_in_ready", {63'd0, in_ready0}, 1);
        model_reset();
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(1); send(1); send(1); send(1);
        chk("post_rst_result", $signed(out_data0), 4);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = 16'($urandom);
            acc_len = 8'($urandom_range(0, 5));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
